// File: rtl/brpred_fetch_pcgen_if.sv
// Fetch PC generator bundle: fetch request, predictor lookup, execute
// resolution, squash and predictor update write.
// The master side is the PC generator; the slave side is its environment.
interface brpred_fetch_pcgen_if #(
  parameter int unsigned p_pc_nbits = 32
);

  // Fetch request
  logic                  imemreq_val;
  logic                  imemreq_rdy;
  logic [p_pc_nbits-1:0] imemreq_addr;

  // Predictor lookup
  logic [p_pc_nbits-1:0] pred_pc;
  logic                  pred_taken;
  logic [p_pc_nbits-1:0] pred_targ;

  // Execute resolution
  logic                  ex_val;
  logic                  ex_is_br;
  logic                  ex_taken;
  logic [p_pc_nbits-1:0] ex_targ;

  // Redirect and predictor update
  logic                  squash;
  logic                  upd_w_en;
  logic [p_pc_nbits-1:0] upd_pc;
  logic [p_pc_nbits-1:0] upd_targ;
  logic                  upd_resolution;

  // Statistics
  logic [31:0]           num_br;
  logic [31:0]           num_mispred;

  modport master (
    output imemreq_val, imemreq_addr, pred_pc, squash,
           upd_w_en, upd_pc, upd_targ, upd_resolution,
           num_br, num_mispred,
    input  imemreq_rdy, pred_taken, pred_targ,
           ex_val, ex_is_br, ex_taken, ex_targ
  );

  modport slave (
    input  imemreq_val, imemreq_addr, pred_pc, squash,
           upd_w_en, upd_pc, upd_targ, upd_resolution,
           num_br, num_mispred,
    output imemreq_rdy, pred_taken, pred_targ,
           ex_val, ex_is_br, ex_taken, ex_targ
  );

endinterface

// File: rtl/brpred_fetch_pcgen.sv
// Fetch-stage next-PC generator. Issues fetch addresses, consults the
// predictor combinationally for the next PC, tracks issued fetches in an
// in-order in-flight queue, and on resolution detects mispredicts,
// redirects fetch, squashes younger work and emits a registered predictor
// update write.
module brpred_fetch_pcgen #(
  parameter int unsigned           p_pc_nbits = 32,
  parameter logic [p_pc_nbits-1:0] p_reset_pc = 32'h0000_0200,
  parameter int unsigned           p_inflight = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  brpred_fetch_pcgen_if.master  bus
);

  localparam int unsigned AW = $clog2(p_inflight);
  localparam int unsigned CW = AW + 1;

  localparam logic [CW-1:0]         CNT_FULL = CW'(p_inflight);
  localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]         CNT_ZERO = '0;
  localparam logic [AW-1:0]         PTR_ONE  = AW'(1);
  localparam logic [p_pc_nbits-1:0] PC_STEP  = p_pc_nbits'(4);

  // Saturating +1 for the 32-bit statistics counters.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Architectural fetch PC
  logic [p_pc_nbits-1:0] r_pc;

  // In-flight queue: data and control kept separately
  logic [p_pc_nbits-1:0] r_q_pc   [p_inflight];
  logic [p_pc_nbits-1:0] r_q_next [p_inflight];
  logic [AW-1:0]         r_head;
  logic [AW-1:0]         r_tail;
  logic [CW-1:0]         r_count;

  // Registered predictor update
  logic                  r_upd_w_en;
  logic [p_pc_nbits-1:0] r_upd_pc;
  logic [p_pc_nbits-1:0] r_upd_targ;
  logic                  r_upd_res;

  // Statistics
  logic [31:0]           r_num_br;
  logic [31:0]           r_num_mispred;

  logic                  w_empty;
  logic                  w_full;
  logic [p_pc_nbits-1:0] w_head_pc;
  logic [p_pc_nbits-1:0] w_head_next;
  logic [p_pc_nbits-1:0] w_actual_next;
  logic [p_pc_nbits-1:0] w_next_pc;
  logic                  w_resolve;
  logic                  w_br_resolve;
  logic                  w_mispred;
  logic                  w_val;
  logic                  w_push;
  logic                  w_pop;

  // full/empty come from the registered count only, so imemreq_val never
  // depends on imemreq_rdy or on the same-cycle pop.
  assign w_empty = (r_count == CNT_ZERO);
  assign w_full  = (r_count == CNT_FULL);

  assign w_head_pc   = r_q_pc[r_head];
  assign w_head_next = r_q_next[r_head];

  // What the oldest instruction really flows to; +4 wraps modulo 2^p_pc_nbits.
  assign w_actual_next = (bus.ex_is_br & bus.ex_taken) ? bus.ex_targ
                                                       : w_head_pc + PC_STEP;

  // A resolve against an empty queue is stale and is ignored entirely.
  assign w_resolve    = bus.ex_val & ~w_empty;
  assign w_br_resolve = w_resolve & bus.ex_is_br;
  assign w_mispred    = w_resolve & (w_actual_next != w_head_next);

  // Predictor lookup is combinational on the current PC.
  assign w_next_pc = bus.pred_taken ? bus.pred_targ : r_pc + PC_STEP;

  // A mispredict kills the request this cycle so nothing younger is pushed.
  assign w_val  = ~w_full & ~w_mispred;
  assign w_push = w_val & bus.imemreq_rdy;
  assign w_pop  = w_resolve & ~w_mispred;

  assign bus.imemreq_val    = w_val;
  assign bus.imemreq_addr   = r_pc;
  assign bus.pred_pc        = r_pc;
  assign bus.squash         = w_mispred;
  assign bus.upd_w_en       = r_upd_w_en;
  assign bus.upd_pc         = r_upd_pc;
  assign bus.upd_targ       = r_upd_targ;
  assign bus.upd_resolution = r_upd_res;
  assign bus.num_br         = r_num_br;
  assign bus.num_mispred    = r_num_mispred;

  // PC register: redirect on mispredict, else advance on an accepted fetch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc <= p_reset_pc;
    end else if (w_mispred) begin
      r_pc <= w_actual_next;
    end else if (w_push) begin
      r_pc <= w_next_pc;
    end
  end

  // Queue control: pointers and occupancy; a mispredict empties the queue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (w_mispred) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + PTR_ONE;
      end
      if (w_pop) begin
        r_head <= r_head + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue payload: issued PC and the next PC that was predicted for it.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_pc[r_tail]   <= r_pc;
      r_q_next[r_tail] <= w_next_pc;
    end
  end

  // Predictor update write, one cycle after a branch resolves.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_upd_w_en <= 1'b0;
      r_upd_pc   <= '0;
      r_upd_targ <= '0;
      r_upd_res  <= 1'b0;
    end else if (w_br_resolve) begin
      r_upd_w_en <= 1'b1;
      r_upd_pc   <= w_head_pc;
      r_upd_targ <= bus.ex_targ;
      r_upd_res  <= bus.ex_taken;
    end else begin
      r_upd_w_en <= 1'b0;
    end
  end

  // Saturating branch and mispredict counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_num_br      <= '0;
      r_num_mispred <= '0;
    end else begin
      if (w_br_resolve) begin
        r_num_br <= sat_inc(r_num_br);
      end
      if (w_mispred) begin
        r_num_mispred <= sat_inc(r_num_mispred);
      end
    end
  end

endmodule

// File: tb/tb_brpred_fetch_pcgen.sv
// Testbench for brpred_fetch_pcgen: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_brpred_fetch_pcgen;

  localparam int unsigned INF = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  brpred_fetch_pcgen_if #(.p_pc_nbits(32)) bus ();

  brpred_fetch_pcgen #(
    .p_pc_nbits (32),
    .p_reset_pc (32'h0000_0200),
    .p_inflight (INF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pnext;
  } ent_t;

  // Reference model state
  ent_t        mq[$];
  logic [31:0] m_pc;
  logic        m_upd_en;
  logic [31:0] m_upd_pc;
  logic [31:0] m_upd_targ;
  logic        m_upd_res;
  logic [31:0] m_nbr;
  logic [31:0] m_nmis;

  // Per-cycle decisions taken by the model for the current inputs
  logic        e_resolve, e_mis, e_fire, e_val;
  logic [31:0] e_actual, e_next;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc       = 32'h0000_0200;
    m_upd_en   = 1'b0;
    m_upd_pc   = '0;
    m_upd_targ = '0;
    m_upd_res  = 1'b0;
    m_nbr      = '0;
    m_nmis     = '0;
  endtask

  // Apply inputs in the low phase, then compare every output with the model.
  task automatic drive(input logic rdy, input logic pt, input logic [31:0] ptg,
                       input logic ev, input logic br, input logic tk,
                       input logic [31:0] tg);
    @(negedge clk);
    bus.imemreq_rdy = rdy;
    bus.pred_taken  = pt;
    bus.pred_targ   = ptg;
    bus.ex_val      = ev;
    bus.ex_is_br    = br;
    bus.ex_taken    = tk;
    bus.ex_targ     = tg;
    #1;
    e_resolve = ev && (mq.size() != 0);
    e_actual  = '0;
    e_mis     = 1'b0;
    if (e_resolve) begin
      e_actual = (br && tk) ? tg : mq[0].pc + 32'd4;
      e_mis    = (e_actual != mq[0].pnext);
    end
    e_val  = (mq.size() < INF) && !e_mis;
    e_fire = e_val && rdy;
    e_next = pt ? ptg : m_pc + 32'd4;

    chk_eq("val",      32'(bus.imemreq_val),    32'(e_val));
    chk_eq("addr",     bus.imemreq_addr,        m_pc);
    chk_eq("pred_pc",  bus.pred_pc,             m_pc);
    chk_eq("squash",   32'(bus.squash),         32'(e_mis));
    chk_eq("upd_w_en", 32'(bus.upd_w_en),       32'(m_upd_en));
    chk_eq("upd_pc",   bus.upd_pc,              m_upd_pc);
    chk_eq("upd_targ", bus.upd_targ,            m_upd_targ);
    chk_eq("upd_res",  32'(bus.upd_resolution), 32'(m_upd_res));
    chk_eq("num_br",   bus.num_br,              m_nbr);
    chk_eq("num_mis",  bus.num_mispred,         m_nmis);
  endtask

  // Clock edge: advance the model with the inputs applied in drive().
  task automatic advance();
    ent_t e;
    @(posedge clk);
    if (e_resolve && bus.ex_is_br) begin
      m_upd_en   = 1'b1;
      m_upd_pc   = mq[0].pc;
      m_upd_targ = bus.ex_targ;
      m_upd_res  = bus.ex_taken;
      if (m_nbr != 32'hFFFF_FFFF) m_nbr = m_nbr + 1;
    end else begin
      m_upd_en = 1'b0;
    end
    if (e_mis) begin
      if (m_nmis != 32'hFFFF_FFFF) m_nmis = m_nmis + 1;
      mq.delete();
      m_pc = e_actual;
    end else begin
      if (e_resolve) void'(mq.pop_front());
      if (e_fire) begin
        e.pc    = m_pc;
        e.pnext = e_next;
        mq.push_back(e);
        m_pc = e_next;
      end
    end
  endtask

  // Asynchronous reset asserted away from any clock edge.
  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b0;
    bus.imemreq_rdy = 1'b0;
    bus.ex_val      = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic step(input logic rdy, input logic pt, input logic [31:0] ptg,
                      input logic ev, input logic br, input logic tk,
                      input logic [31:0] tg);
    drive(rdy, pt, ptg, ev, br, tk, tg);
    advance();
  endtask

  initial begin
    logic        rdy, pt, ev, br, tk;
    logic [31:0] ptg, tg;

    bus.imemreq_rdy = 1'b0;
    bus.pred_taken  = 1'b0;
    bus.pred_targ   = '0;
    bus.ex_val      = 1'b0;
    bus.ex_is_br    = 1'b0;
    bus.ex_taken    = 1'b0;
    bus.ex_targ     = '0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Sequential fetch until the queue fills
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk_eq("seq_addr", bus.imemreq_addr, 32'h200 + 32'(4 * i));
      advance();
    end
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk_eq("full_val", 32'(bus.imemreq_val), 32'd0);
    chk_eq("full_upd", 32'(bus.upd_w_en), 32'd0);
    advance();

    do_reset();

    // Taken prediction, correct resolve, then a mispredict
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 32'h400, 1'b0, 1'b0, 1'b0, 32'h0);
    chk_eq("addr_204", bus.imemreq_addr, 32'h204);
    advance();
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk_eq("addr_400", bus.imemreq_addr, 32'h400);
    advance();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h400);
    chk_eq("no_squash", 32'(bus.squash), 32'd0);
    advance();
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h300);
    chk_eq("upd_en1", 32'(bus.upd_w_en), 32'd1);
    chk_eq("upd_pc1", bus.upd_pc, 32'h204);
    chk_eq("upd_tg1", bus.upd_targ, 32'h400);
    chk_eq("squash1", 32'(bus.squash), 32'd1);
    chk_eq("mis_val", 32'(bus.imemreq_val), 32'd0);
    advance();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk_eq("redir", bus.imemreq_addr, 32'h300);
    chk_eq("nmis1", bus.num_mispred, 32'd1);
    chk_eq("upd_res2", 32'(bus.upd_resolution), 32'd1);
    advance();
    drive(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 32'h0);
    chk_eq("empty_ev", 32'(bus.upd_w_en), 32'd0);
    chk_eq("nbr2", bus.num_br, 32'd2);
    advance();
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk_eq("wrap", bus.imemreq_addr, 32'h0);
    advance();
    // Three in flight: simultaneous push and correct pop keeps count at 3
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk_eq("cnt3_val", 32'(bus.imemreq_val), 32'd1);
    advance();
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk_eq("cnt4_val", 32'(bus.imemreq_val), 32'd0);
    advance();

    // Reset with entries in flight
    do_reset();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk_eq("rst_addr", bus.imemreq_addr, 32'h200);
    chk_eq("rst_nbr", bus.num_br, 32'd0);
    chk_eq("rst_nmis", bus.num_mispred, 32'd0);
    chk_eq("rst_sq", 32'(bus.squash), 32'd0);
    chk_eq("rst_val", 32'(bus.imemreq_val), 32'd1);
    advance();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      rdy = ($urandom_range(0, 3) != 0);
      pt  = ($urandom_range(0, 2) == 0);
      ptg = $urandom & 32'hFFFF_FFFC;
      ev  = ($urandom_range(0, 2) == 0);
      br  = $urandom_range(0, 1) == 1;
      tk  = $urandom_range(0, 1) == 1;
      tg  = $urandom & 32'hFFFF_FFFC;
      if (mq.size() != 0 && $urandom_range(0, 3) != 0) begin
        if (mq[0].pnext == mq[0].pc + 32'd4) begin
          tk = 1'b0;
        end else begin
          br = 1'b1;
          tk = 1'b1;
          tg = mq[0].pnext;
        end
      end
      step(rdy, pt, ptg, ev, br, tk, tg);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
